hazard_scoreboard: RTL

//  Issue controller for decode: per-register pending-write scoreboard for the regfile.

---
 rtl/hazard_scoreboard.sv | 111 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Decode issue controller: per-register pending-write scoreboard producing stalls, bubbles and flushes.
// Optional same-cycle writeback-to-decode bypass enabled by defining HAZARD_WB_BYPASS_EN.
module hazard_scoreboard #(
    parameter int  NUM_REG = 32,
    localparam int RegBits = $clog2(NUM_REG)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid_in,
    input  logic [RegBits-1:0] rs1_in,
    input  logic [RegBits-1:0] rs2_in,
    input  logic               rs1_used_in,
    input  logic               rs2_used_in,
    input  logic [RegBits-1:0] rd_in,
    input  logic               rd_write_in,
    input  logic               wb_valid_in,
    input  logic [RegBits-1:0] wb_rd_in,
    input  logic               mem_stall_in,
    input  logic               branch_taken_in,
    output logic               stall_fetch,
    output logic               stall_decode,
    output logic               bubble_execute,
    output logic               flush_decode,
    output logic               fwd_rs1,
    output logic               fwd_rs2,
    output logic [RegBits:0]   pending_count
);
    typedef enum logic {RUN, MEMWAIT} state_e;

    state_e             state_q, state_d;
    logic [NUM_REG-1:0] pend_q, pend_d;
    logic [RegBits:0]   pending_count_q, pending_count_d;
    logic               byp1, byp2, raw, waw, hazard, issue, set_en, clr_en, inc, dec;

    always_comb begin
`ifdef HAZARD_WB_BYPASS_EN
        byp1 = wb_valid_in & (wb_rd_in == rs1_in);
        byp2 = wb_valid_in & (wb_rd_in == rs2_in);
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        raw = id_valid_in &
              ((rs1_used_in & (rs1_in != '0) & pend_q[rs1_in] & ~byp1) |
               (rs2_used_in & (rs2_in != '0) & pend_q[rs2_in] & ~byp2));
        // A writeback retiring the same destination this cycle resolves the WAW.
        waw = id_valid_in & rd_write_in & (rd_in != '0) & pend_q[rd_in] &
              ~(wb_valid_in & (wb_rd_in == rd_in));
        hazard = raw | waw;
        issue  = id_valid_in & ~hazard & ~mem_stall_in & ~branch_taken_in;
        set_en = issue & rd_write_in & (rd_in != '0);
        clr_en = wb_valid_in & (wb_rd_in != '0);

        pend_d = pend_q;
        if (clr_en) pend_d[wb_rd_in] = 1'b0;
        if (set_en) pend_d[rd_in] = 1'b1;
        pend_d[0] = 1'b0;

        // Count only real bit transitions so the counter always equals popcount(pend).
        inc = set_en & ~pend_q[rd_in];
        dec = clr_en & pend_q[wb_rd_in] & ~(set_en & (wb_rd_in == rd_in));
        pending_count_d = pending_count_q + (RegBits+1)'(inc) - (RegBits+1)'(dec);

        state_d = state_q;
        case (state_q)
            RUN:     if (mem_stall_in) state_d = MEMWAIT;
            MEMWAIT: if (!mem_stall_in) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_fetch    = 1'b0;
        stall_decode   = 1'b0;
        bubble_execute = 1'b0;
        flush_decode   = 1'b0;
        fwd_rs1        = 1'b0;
        fwd_rs2        = 1'b0;
        pending_count  = '0;
        if (reset) begin
            pending_count = pending_count_q;
            if (mem_stall_in) begin
                stall_fetch  = 1'b1;
                stall_decode = 1'b1;
            end else if (branch_taken_in) begin
                flush_decode   = 1'b1;
                bubble_execute = 1'b1;
            end else if (hazard) begin
                stall_fetch    = 1'b1;
                stall_decode   = 1'b1;
                bubble_execute = 1'b1;
            end
`ifdef HAZARD_WB_BYPASS_EN
            fwd_rs1 = rs1_used_in & byp1 & (rs1_in != '0);
            fwd_rs2 = rs2_used_in & byp2 & (rs2_in != '0);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= RUN;
            pend_q          <= '0;
            pending_count_q <= '0;
        end else begin
            state_q         <= state_d;
            pend_q          <= pend_d;
            pending_count_q <= pending_count_d;
        end
    end
endmodule
